// File: rtl/ff_ctrl_pkg.sv
// Shared mode encodings, FSM state type and strobe helper for the flip-flop store sequencer.
package ff_ctrl_pkg;

   localparam logic [1:0] MODE_BCAST = 2'b00;
   localparam logic [1:0] MODE_RR    = 2'b01;
   localparam logic [1:0] MODE_BURST = 2'b10;
   localparam logic [1:0] MODE_RSVD  = 2'b11;

   localparam int MAX_ELEM = 4;

   typedef enum logic {
      IDLE,
      BURST
   } state_e;

   // Indices at or beyond num_elem yield an all-zero strobe.
   function automatic logic [MAX_ELEM-1:0] onehot(input logic [1:0] idx, input int num_elem);
      logic [MAX_ELEM-1:0] v;
      v = '0;
      if (int'(idx) < num_elem) v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/ff_store_sequencer_if.sv
// Button/mode inputs and store-strobe/status outputs of the flip-flop store sequencer.
interface ff_store_sequencer_if #(
   parameter int NUM_ELEM = 3
);
   logic                btn_raw;
   logic [1:0]          mode;
   logic [NUM_ELEM-1:0] store_en;
   logic                busy;
   logic [1:0]          rr_ptr;
   logic                overrun;
   logic                btn_db;

   modport master (
      output btn_raw, mode,
      input  store_en, busy, rr_ptr, overrun, btn_db
   );

   modport slave (
      input  btn_raw, mode,
      output store_en, busy, rr_ptr, overrun, btn_db
   );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-count debouncer; emits a one-cycle press_evt on each
// debounced rising edge, aligned with the first high cycle of btn_db.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw_i,
   output logic btn_db_o,
   output logic press_evt_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);

   logic [1:0]    sync_q;
   logic          btn_s;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          btn_db_q, btn_db_d;
   logic          press_evt_q;

   assign btn_s = sync_q[1];

   always_comb begin
      // NOTE: defaults first, so no branch leaves a variable unassigned and infers a latch.
      cnt_d    = cnt_q;
      btn_db_d = btn_db_q;
      if (btn_s == btn_db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
         btn_db_d = btn_s;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q      <= '0;
         cnt_q       <= '0;
         btn_db_q    <= 1'b0;
         press_evt_q <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], btn_raw_i};
         cnt_q       <= cnt_d;
         btn_db_q    <= btn_db_d;
         press_evt_q <= btn_db_d & ~btn_db_q;
      end
   end

   assign btn_db_o    = btn_db_q;
   assign press_evt_o = press_evt_q;

endmodule

// File: rtl/ff_store_sequencer.sv
// Store-strobe sequencer for the D/JK/T flip-flop bank: broadcast, round-robin or burst per press.
// Optional hold-to-repeat press events are enabled by defining FF_SEQ_AUTO_REPEAT_EN.
module ff_store_sequencer
   import ff_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int NUM_ELEM        = 3,
   parameter int REPEAT_CYCLES   = 50000000
) (
   input  logic                  clk,
   input  logic                  reset,
   ff_store_sequencer_if.slave   bus
);

   if (DEBOUNCE_CYCLES < 2 || NUM_ELEM < 2 || NUM_ELEM > MAX_ELEM || REPEAT_CYCLES < 2) begin : g_bad_param
      $error("ff_store_sequencer: illegal parameter value");
   end

   logic                press_evt;
   logic                btn_db;
   logic                evt;
   state_e              state_q;
   logic [1:0]          idx_q;
   logic [1:0]          rr_ptr_q;
   logic [NUM_ELEM-1:0] store_en_q;
   logic                busy_q;
   logic                overrun_q;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .btn_raw_i  (bus.btn_raw),
      .btn_db_o   (btn_db),
      .press_evt_o(press_evt)
   );

`ifdef FF_SEQ_AUTO_REPEAT_EN
   localparam int HW = $clog2(REPEAT_CYCLES);

   logic [HW-1:0] hold_q, hold_d;
   logic          rep_evt;

   assign rep_evt = btn_db && (hold_q == HW'(REPEAT_CYCLES - 1));
   assign evt     = press_evt | rep_evt;

   // Counter restarts on any event and holds its value while a burst runs.
   always_comb begin
      hold_d = hold_q;
      if (!btn_db || evt)      hold_d = '0;
      else if (state_q == IDLE) hold_d = hold_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) hold_q <= '0;
      else       hold_q <= hold_d;
   end
`else
   assign evt = press_evt;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         rr_ptr_q   <= '0;
         store_en_q <= '0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         store_en_q <= '0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (evt) begin
                  case (bus.mode)
                     MODE_RR: begin
                        store_en_q <= NUM_ELEM'(onehot(rr_ptr_q, NUM_ELEM));
                        rr_ptr_q   <= (rr_ptr_q == 2'(NUM_ELEM - 1)) ? 2'd0 : rr_ptr_q + 2'd1;
                     end
                     MODE_BURST: begin
                        store_en_q <= NUM_ELEM'(onehot(2'd0, NUM_ELEM));
                        busy_q     <= 1'b1;
                        idx_q      <= 2'd1;
                        state_q    <= BURST;
                     end
                     MODE_BCAST, MODE_RSVD: store_en_q <= '1;
                  endcase
               end
            end
            BURST: begin
               // Outputs describe the strobe being issued, so busy stays high on the last one.
               store_en_q <= NUM_ELEM'(onehot(idx_q, NUM_ELEM));
               busy_q     <= 1'b1;
               overrun_q  <= evt;
               if (idx_q == 2'(NUM_ELEM - 1)) state_q <= IDLE;
               else                           idx_q   <= idx_q + 2'd1;
            end
         endcase
      end
   end

   assign bus.store_en = store_en_q;
   assign bus.busy     = busy_q;
   assign bus.rr_ptr   = rr_ptr_q;
   assign bus.overrun  = overrun_q;
   assign bus.btn_db   = btn_db;

endmodule

// File: tb/tb_ff_store_sequencer.sv
// Directed self-checking bench for ff_store_sequencer (DEBOUNCE_CYCLES=4, NUM_ELEM=3, REPEAT_CYCLES=10).
module tb_ff_store_sequencer;
   import ff_ctrl_pkg::*;

   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   logic [2:0] se_log[$];
   int         cyc_log[$];
   logic [1:0] rr_log[$];
   int         ovr_cnt, busy_cnt, db_high_cnt;

   logic [2:0] rr_exp_se [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
   logic [1:0] rr_exp_ptr[4] = '{2'd1, 2'd2, 2'd0, 2'd1};

   ff_store_sequencer_if #(.NUM_ELEM(3)) bus ();

   ff_store_sequencer #(
      .DEBOUNCE_CYCLES(4),
      .NUM_ELEM       (3),
      .REPEAT_CYCLES  (10)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.store_en != '0) begin
         se_log.push_back(bus.store_en);
         cyc_log.push_back(cyc);
         rr_log.push_back(bus.rr_ptr);
      end
      if (bus.overrun) ovr_cnt++;
      if (bus.busy)    busy_cnt++;
      if (bus.btn_db)  db_high_cnt++;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic clear_log();
      se_log.delete();
      cyc_log.delete();
      rr_log.delete();
      ovr_cnt     = 0;
      busy_cnt    = 0;
      db_high_cnt = 0;
   endtask

   initial begin
      reset       = 1'b1;
      bus.btn_raw = 1'b0;
      bus.mode    = MODE_BCAST;
      clear_log();
      run(3);
      check("rst_store_en", bus.store_en, 3'b000);
      check("rst_busy",     bus.busy,     1'b0);
      check("rst_rr_ptr",   bus.rr_ptr,   2'd0);
      check("rst_overrun",  bus.overrun,  1'b0);
      check("rst_btn_db",   bus.btn_db,   1'b0);
      reset = 1'b0;

      // Bounce: 2-cycle toggles for 20 cycles, then a steady high level.
      clear_log();
      for (int i = 0; i < 10; i++) begin
         bus.btn_raw = ~i[0];
         run(2);
      end
      check("bounce_db_high_cycles", db_high_cnt,   0);
      check("bounce_strobes",        se_log.size(), 0);
      bus.btn_raw = 1'b1;
      run(12);
      check("settle_strobes", se_log.size(), 1);
      check("settle_value",   se_log[0],     3'b111);
      check("settle_btn_db",  bus.btn_db,    1'b1);
      clear_log();
      bus.btn_raw = 1'b0;
      run(10);
      check("release_strobes", se_log.size(), 0);
      check("release_btn_db",  bus.btn_db,    1'b0);

      // Broadcast with exact latency: strobe 7 cycles after the press starts.
      clear_log();
      bus.btn_raw = 1'b1;
      run(6);
      check("bcast_db_rise",    bus.btn_db,   1'b1);
      check("bcast_pre_strobe", bus.store_en, 3'b000);
      tick();
      check("bcast_strobe",     bus.store_en, 3'b111);
      check("bcast_rr_ptr",     bus.rr_ptr,   2'd0);
      tick();
      check("bcast_one_cycle",  bus.store_en, 3'b000);
      bus.btn_raw = 1'b0;
      run(10);

      // Round-robin across the wrap point.
      bus.mode = MODE_RR;
      for (int p = 0; p < 4; p++) begin
         clear_log();
         bus.btn_raw = 1'b1;
         run(8);
         bus.btn_raw = 1'b0;
         run(10);
         check($sformatf("rr%0d_strobes", p), se_log.size(), 1);
         check($sformatf("rr%0d_store",   p), se_log[0],     rr_exp_se[p]);
         check($sformatf("rr%0d_ptr",     p), bus.rr_ptr,    rr_exp_ptr[p]);
      end

      // Burst with a dropped event and a mode change mid-burst. The debouncer cannot
      // produce two press events within three cycles, so the second one is injected.
      bus.mode = MODE_BURST;
      clear_log();
      bus.btn_raw = 1'b1;
      run(7);
      check("burst0_store", bus.store_en, 3'b001);
      check("burst0_busy",  bus.busy,     1'b1);
      force dut.press_evt = 1'b1;
      bus.mode = MODE_BCAST;
      tick();
      release dut.press_evt;
      check("burst1_store",   bus.store_en, 3'b010);
      check("burst1_busy",    bus.busy,     1'b1);
      check("burst1_overrun", bus.overrun,  1'b1);
      tick();
      check("burst2_store",   bus.store_en, 3'b100);
      check("burst2_busy",    bus.busy,     1'b1);
      check("burst2_overrun", bus.overrun,  1'b0);
      bus.btn_raw = 1'b0;
      tick();
      check("burst_end_store", bus.store_en, 3'b000);
      check("burst_end_busy",  bus.busy,     1'b0);
      check("burst_busy_cycles",    busy_cnt,      3);
      check("burst_overrun_pulses", ovr_cnt,       1);
      check("burst_strobes",        se_log.size(), 3);
      check("burst_rr_ptr",         bus.rr_ptr,    2'd1);
      run(10);
      clear_log();
      bus.btn_raw = 1'b1;
      run(8);
      bus.btn_raw = 1'b0;
      run(10);
      check("mode_change_strobes", se_log.size(), 1);
      check("mode_change_store",   se_log[0],     3'b111);

      // Reset on the second burst cycle.
      bus.mode = MODE_BURST;
      clear_log();
      bus.btn_raw = 1'b1;
      run(8);
      check("rstb_pre_store", bus.store_en, 3'b010);
      reset       = 1'b1;
      bus.btn_raw = 1'b0;
      tick();
      check("rstb_store",  bus.store_en, 3'b000);
      check("rstb_busy",   bus.busy,     1'b0);
      check("rstb_rr_ptr", bus.rr_ptr,   2'd0);
      reset = 1'b0;
      clear_log();
      run(10);
      check("rstb_after_strobes", se_log.size(), 0);
      check("rstb_after_busy",    busy_cnt,      0);

`ifdef FF_SEQ_AUTO_REPEAT_EN
      // Hold with btn_db high for 35 cycles: initial strobe plus three repeats.
      bus.mode = MODE_RR;
      clear_log();
      bus.btn_raw = 1'b1;
      run(6);
      check("rep_db_rise", bus.btn_db, 1'b1);
      run(29);
      bus.btn_raw = 1'b0;
      run(20);
      check("rep_strobes", se_log.size(), 4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("rep%0d_store", k), se_log[k], rr_exp_se[k]);
         check($sformatf("rep%0d_ptr",   k), rr_log[k], rr_exp_ptr[k]);
         if (k > 0) check($sformatf("rep%0d_spacing", k), cyc_log[k] - cyc_log[k-1], 10);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
